// File: rtl/pong_pkg.sv
// Shared constants for the pong display path: VGA timing, sprite geometry
// and the winner encoding, plus the clamped subtract used by the hit tests.
package pong_pkg;

    localparam int H_ACTIVE_DFLT = 640;
    localparam int HSYNC_FIRST   = 656;
    localparam int HSYNC_LAST    = 751;
    localparam int LINE_PERIOD   = 800;

    localparam int V_ACTIVE_DFLT = 480;
    localparam int VSYNC_FIRST   = 490;
    localparam int VSYNC_LAST    = 491;
    localparam int FRAME_PERIOD  = 525;

    localparam int P1_X_DFLT       = 80;
    localparam int P2_X_DFLT       = 560;
    localparam int PAD_HALF_W_DFLT = 25;
    localparam int PAD_HALF_H_DFLT = 33;
    localparam int BALL_W_DFLT     = 12;
    localparam int BALL_H_DFLT     = 17;
    localparam int BALL_XINIT_DFLT = 320;
    localparam int BALL_YINIT_DFLT = 240;
    localparam int PAD_YINIT_DFLT  = 240;

    // Hit arithmetic width: wide enough that ball_x + BALL_W never wraps.
    localparam int HIT_W = 11;

    typedef enum logic [2:0] {
        WIN_NONE = 3'd0,
        WIN_P1   = 3'd1,
        WIN_P2   = 3'd2
    } winner_e;

    function automatic logic [HIT_W-1:0] clamp_sub(input logic [HIT_W-1:0] a,
                                                   input logic [HIT_W-1:0] b);
        return (a >= b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/game_frame_sync_box_hit.sv
// Combinational inclusive box test. The box spans ref-BELOW..ref+ABOVE on
// each axis, with lower bounds clamped at zero instead of wrapping.
module box_hit
    import pong_pkg::*;
#(
    parameter int X_BELOW = 0,
    parameter int X_ABOVE = 0,
    parameter int Y_BELOW = 0,
    parameter int Y_ABOVE = 0
) (
    input  logic [HIT_W-1:0] px,
    input  logic [HIT_W-1:0] py,
    input  logic [HIT_W-1:0] x_ref,
    input  logic [HIT_W-1:0] y_ref,
    output logic             hit
);

    localparam logic [HIT_W-1:0] XB = HIT_W'(X_BELOW);
    localparam logic [HIT_W-1:0] XA = HIT_W'(X_ABOVE);
    localparam logic [HIT_W-1:0] YB = HIT_W'(Y_BELOW);
    localparam logic [HIT_W-1:0] YA = HIT_W'(Y_ABOVE);

    logic [HIT_W-1:0] x_lo;
    logic [HIT_W-1:0] x_hi;
    logic [HIT_W-1:0] y_lo;
    logic [HIT_W-1:0] y_hi;

    always_comb begin
        x_lo = clamp_sub(x_ref, XB);
        x_hi = x_ref + XA;
        y_lo = clamp_sub(y_ref, YB);
        y_hi = y_ref + YA;
        hit  = (px >= x_lo) && (px <= x_hi) && (py >= y_lo) && (py <= y_hi);
    end

endmodule

// File: rtl/game_frame_sync.sv
// VGA raster timing, screenEnd frame event and per-frame snapshot of the
// regfile state, with registered sprite-hit flags aligned to x/y.
module game_frame_sync
    import pong_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DFLT,
    parameter int H_FP       = HSYNC_FIRST - H_ACTIVE_DFLT,
    parameter int H_SYNC     = HSYNC_LAST - HSYNC_FIRST + 1,
    parameter int H_BP       = LINE_PERIOD - 1 - HSYNC_LAST,
    parameter int V_ACTIVE   = V_ACTIVE_DFLT,
    parameter int V_FP       = VSYNC_FIRST - V_ACTIVE_DFLT,
    parameter int V_SYNC     = VSYNC_LAST - VSYNC_FIRST + 1,
    parameter int V_BP       = FRAME_PERIOD - 1 - VSYNC_LAST,
    parameter int P1_X       = P1_X_DFLT,
    parameter int P2_X       = P2_X_DFLT,
    parameter int PAD_HALF_W = PAD_HALF_W_DFLT,
    parameter int PAD_HALF_H = PAD_HALF_H_DFLT,
    parameter int BALL_W     = BALL_W_DFLT,
    parameter int BALL_H     = BALL_H_DFLT,
    parameter int BALL_XINIT = BALL_XINIT_DFLT,
    parameter int BALL_YINIT = BALL_YINIT_DFLT,
    parameter int PAD_YINIT  = PAD_YINIT_DFLT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pix_en,
    input  logic [9:0] ball_x,
    input  logic [8:0] ball_y,
    input  logic [8:0] p1_yRef,
    input  logic [8:0] p2_yRef,
    input  logic [2:0] winner,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       screenEnd,
    output logic       screenEnd_pulse,
    output logic       in_ball,
    output logic       in_p1,
    output logic       in_p2,
    output logic [9:0] ball_x_q,
    output logic [8:0] ball_y_q,
    output logic [8:0] p1_y_q,
    output logic [8:0] p2_y_q,
    output logic [2:0] winner_q
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] V_ACT_M1 = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic [HIT_W-1:0] P1_XREF = HIT_W'(P1_X);
    localparam logic [HIT_W-1:0] P2_XREF = HIT_W'(P2_X);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       frame_wrap;

    logic [9:0] ball_x_d;
    logic [8:0] ball_y_d;
    logic [8:0] p1_y_d;
    logic [8:0] p2_y_d;
    logic [2:0] winner_d;

    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;
    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic       screen_end_q, screen_end_d;
    logic       screen_end_pulse_q, screen_end_pulse_d;
    logic       in_ball_q, in_ball_d;
    logic       in_p1_q, in_p1_d;
    logic       in_p2_q, in_p2_d;

    logic [HIT_W-1:0] px;
    logic [HIT_W-1:0] py;
    logic             ball_hit;
    logic             p1_hit;
    logic             p2_hit;

    // frame_wrap marks the pix_en edge that moves the raster into the
    // vertical blank; the snapshot loads on exactly that edge.
    always_comb begin
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        frame_wrap = 1'b0;
        if (pix_en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d    = '0;
                v_cnt_d    = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
                frame_wrap = (v_cnt_q == V_ACT_M1);
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    always_comb begin
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        p1_y_d   = p1_y_q;
        p2_y_d   = p2_y_q;
        winner_d = winner_q;
        if (frame_wrap) begin
            ball_x_d = ball_x;
            ball_y_d = ball_y;
            p1_y_d   = p1_yRef;
            p2_y_d   = p2_yRef;
            winner_d = winner;
        end
    end

    assign px = {1'b0, h_cnt_q};
    assign py = {1'b0, v_cnt_q};

    box_hit #(
        .X_BELOW(0),
        .X_ABOVE(BALL_W - 1),
        .Y_BELOW(0),
        .Y_ABOVE(BALL_H - 1)
    ) u_ball_hit (
        .px   (px),
        .py   (py),
        .x_ref({1'b0, ball_x_q}),
        .y_ref({2'b00, ball_y_q}),
        .hit  (ball_hit)
    );

    box_hit #(
        .X_BELOW(PAD_HALF_W),
        .X_ABOVE(PAD_HALF_W),
        .Y_BELOW(PAD_HALF_H),
        .Y_ABOVE(PAD_HALF_H)
    ) u_p1_hit (
        .px   (px),
        .py   (py),
        .x_ref(P1_XREF),
        .y_ref({2'b00, p1_y_q}),
        .hit  (p1_hit)
    );

    box_hit #(
        .X_BELOW(PAD_HALF_W),
        .X_ABOVE(PAD_HALF_W),
        .Y_BELOW(PAD_HALF_H),
        .Y_ABOVE(PAD_HALF_H)
    ) u_p2_hit (
        .px   (px),
        .py   (py),
        .x_ref(P2_XREF),
        .y_ref({2'b00, p2_y_q}),
        .hit  (p2_hit)
    );

    // The output stage re-registers the counter decode every clock; because
    // the counters hold while pix_en is low, so do these, except the pulse.
    always_comb begin
        video_on_d         = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hsync_d            = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
        vsync_d            = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
        x_d                = h_cnt_q;
        y_d                = v_cnt_q[8:0];
        screen_end_d       = (v_cnt_q >= V_ACT);
        screen_end_pulse_d = screen_end_d && !screen_end_q;
        in_ball_d          = video_on_d && ball_hit && (winner_q == WIN_NONE);
        in_p1_d            = video_on_d && p1_hit;
        in_p2_d            = video_on_d && p2_hit;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_cnt_q            <= '0;
            v_cnt_q            <= '0;
            ball_x_q           <= 10'(BALL_XINIT);
            ball_y_q           <= 9'(BALL_YINIT);
            p1_y_q             <= 9'(PAD_YINIT);
            p2_y_q             <= 9'(PAD_YINIT);
            winner_q           <= WIN_NONE;
            hsync_q            <= 1'b1;
            vsync_q            <= 1'b1;
            video_on_q         <= 1'b0;
            x_q                <= '0;
            y_q                <= '0;
            screen_end_q       <= 1'b0;
            screen_end_pulse_q <= 1'b0;
            in_ball_q          <= 1'b0;
            in_p1_q            <= 1'b0;
            in_p2_q            <= 1'b0;
        end else begin
            h_cnt_q            <= h_cnt_d;
            v_cnt_q            <= v_cnt_d;
            ball_x_q           <= ball_x_d;
            ball_y_q           <= ball_y_d;
            p1_y_q             <= p1_y_d;
            p2_y_q             <= p2_y_d;
            winner_q           <= winner_d;
            hsync_q            <= hsync_d;
            vsync_q            <= vsync_d;
            video_on_q         <= video_on_d;
            x_q                <= x_d;
            y_q                <= y_d;
            screen_end_q       <= screen_end_d;
            screen_end_pulse_q <= screen_end_pulse_d;
            in_ball_q          <= in_ball_d;
            in_p1_q            <= in_p1_d;
            in_p2_q            <= in_p2_d;
        end
    end

    assign hsync           = hsync_q;
    assign vsync           = vsync_q;
    assign video_on        = video_on_q;
    assign x               = x_q;
    assign y               = y_q;
    assign screenEnd       = screen_end_q;
    assign screenEnd_pulse = screen_end_pulse_q;
    assign in_ball         = in_ball_q;
    assign in_p1           = in_p1_q;
    assign in_p2           = in_p2_q;

endmodule

// File: tb/tb_game_frame_sync.sv
// Scoreboard bench for game_frame_sync on a scaled-down raster so that
// several whole frames, a mid-frame reset and random pix_en fit the run.
module tb_game_frame_sync;

    localparam int H_ACTIVE   = 40;
    localparam int H_FP       = 4;
    localparam int H_SYNC     = 6;
    localparam int H_BP       = 6;
    localparam int V_ACTIVE   = 30;
    localparam int V_FP       = 3;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 5;
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME_CLKS = H_TOTAL * V_TOTAL;
    localparam int P1_X       = 8;
    localparam int P2_X       = 30;
    localparam int PAD_HALF_W = 3;
    localparam int PAD_HALF_H = 4;
    localparam int BALL_W     = 4;
    localparam int BALL_H     = 5;
    localparam int BALL_XINIT = 20;
    localparam int BALL_YINIT = 15;
    localparam int PAD_YINIT  = 15;

    logic       clock;
    logic       reset;
    logic       pix_en;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [8:0] p1_yRef;
    logic [8:0] p2_yRef;
    logic [2:0] winner;
    logic       hsync, vsync, video_on;
    logic [9:0] x;
    logic [8:0] y;
    logic       screenEnd, screenEnd_pulse;
    logic       in_ball, in_p1, in_p2;
    logic [9:0] ball_x_q;
    logic [8:0] ball_y_q, p1_y_q, p2_y_q;
    logic [2:0] winner_q;

    typedef struct {
        int hsync;
        int vsync;
        int video_on;
        int check_xy;
        int x;
        int y;
        int se;
        int sep;
        int in_ball;
        int in_p1;
        int in_p2;
        int bx;
        int by;
        int p1;
        int p2;
        int win;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int   m_pix;
    int   m_bx, m_by, m_p1, m_p2, m_win;
    int   m_prev_se;

    game_frame_sync #(
        .H_ACTIVE  (H_ACTIVE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_ACTIVE  (V_ACTIVE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP),
        .P1_X      (P1_X),
        .P2_X      (P2_X),
        .PAD_HALF_W(PAD_HALF_W),
        .PAD_HALF_H(PAD_HALF_H),
        .BALL_W    (BALL_W),
        .BALL_H    (BALL_H),
        .BALL_XINIT(BALL_XINIT),
        .BALL_YINIT(BALL_YINIT),
        .PAD_YINIT (PAD_YINIT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .pix_en         (pix_en),
        .ball_x         (ball_x),
        .ball_y         (ball_y),
        .p1_yRef        (p1_yRef),
        .p2_yRef        (p2_yRef),
        .winner         (winner),
        .hsync          (hsync),
        .vsync          (vsync),
        .video_on       (video_on),
        .x              (x),
        .y              (y),
        .screenEnd      (screenEnd),
        .screenEnd_pulse(screenEnd_pulse),
        .in_ball        (in_ball),
        .in_p1          (in_p1),
        .in_p2          (in_p2),
        .ball_x_q       (ball_x_q),
        .ball_y_q       (ball_y_q),
        .p1_y_q         (p1_y_q),
        .p2_y_q         (p2_y_q),
        .winner_q       (winner_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.hsync = 1; e.vsync = 1; e.video_on = 0; e.check_xy = 1;
        e.x = 0; e.y = 0; e.se = 0; e.sep = 0;
        e.in_ball = 0; e.in_p1 = 0; e.in_p2 = 0;
        e.bx = BALL_XINIT; e.by = BALL_YINIT;
        e.p1 = PAD_YINIT; e.p2 = PAD_YINIT; e.win = 0;
        return e;
    endfunction

    // Reference model: tracks the pixel index since reset and derives the
    // raster position by division; each clock it predicts the outputs.
    always @(posedge clock or posedge reset) begin : ref_model
        exp_t e;
        int   h, v;
        if (reset) begin
            exp_q.delete();
            m_pix = 0;
            m_bx = BALL_XINIT; m_by = BALL_YINIT;
            m_p1 = PAD_YINIT;  m_p2 = PAD_YINIT;
            m_win = 0;
            m_prev_se = 0;
            exp_q.push_back(reset_exp());
        end else begin
            h = m_pix % H_TOTAL;
            v = m_pix / H_TOTAL;
            e.video_on = int'(h < H_ACTIVE && v < V_ACTIVE);
            e.hsync    = int'(!(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC));
            e.vsync    = int'(!(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC));
            e.check_xy = e.video_on;
            e.x        = h;
            e.y        = v;
            e.se       = int'(v >= V_ACTIVE);
            e.sep      = int'(e.se == 1 && m_prev_se == 0);
            m_prev_se  = e.se;
            e.in_ball  = int'(e.video_on == 1 && m_win == 0 &&
                              h >= m_bx && h <= m_bx + BALL_W - 1 &&
                              v >= m_by && v <= m_by + BALL_H - 1);
            e.in_p1    = int'(e.video_on == 1 &&
                              h >= P1_X - PAD_HALF_W && h <= P1_X + PAD_HALF_W &&
                              v >= m_p1 - PAD_HALF_H && v <= m_p1 + PAD_HALF_H);
            e.in_p2    = int'(e.video_on == 1 &&
                              h >= P2_X - PAD_HALF_W && h <= P2_X + PAD_HALF_W &&
                              v >= m_p2 - PAD_HALF_H && v <= m_p2 + PAD_HALF_H);
            if (pix_en) begin
                if (m_pix == H_TOTAL * V_ACTIVE - 1) begin
                    m_bx  = int'(ball_x);
                    m_by  = int'(ball_y);
                    m_p1  = int'(p1_yRef);
                    m_p2  = int'(p2_yRef);
                    m_win = int'(winner);
                end
                m_pix = (m_pix + 1) % FRAME_CLKS;
            end
            e.bx = m_bx; e.by = m_by; e.p1 = m_p1; e.p2 = m_p2; e.win = m_win;
            exp_q.push_back(e);
        end
    end

    always @(negedge clock) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("hsync", int'(hsync), e.hsync);
            checkOutput("vsync", int'(vsync), e.vsync);
            checkOutput("video_on", int'(video_on), e.video_on);
            if (e.check_xy == 1) begin
                checkOutput("x", int'(x), e.x);
                checkOutput("y", int'(y), e.y);
            end
            checkOutput("screenEnd", int'(screenEnd), e.se);
            checkOutput("screenEnd_pulse", int'(screenEnd_pulse), e.sep);
            checkOutput("in_ball", int'(in_ball), e.in_ball);
            checkOutput("in_p1", int'(in_p1), e.in_p1);
            checkOutput("in_p2", int'(in_p2), e.in_p2);
            checkOutput("ball_x_q", int'(ball_x_q), e.bx);
            checkOutput("ball_y_q", int'(ball_y_q), e.by);
            checkOutput("p1_y_q", int'(p1_y_q), e.p1);
            checkOutput("p2_y_q", int'(p2_y_q), e.p2);
            checkOutput("winner_q", int'(winner_q), e.win);
        end
    end

    task automatic randomize_inputs();
        ball_x  = 10'($urandom_range(H_ACTIVE + 6));
        ball_y  = 9'($urandom_range(V_ACTIVE + 4));
        p1_yRef = 9'($urandom_range(V_ACTIVE + 4));
        p2_yRef = 9'($urandom_range(V_ACTIVE + 4));
        winner  = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'd0;
    endtask

    task automatic applyStimulus(input int cycles, input int pe_pct, input int chg_pct);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
            pix_en = ($urandom_range(99) < pe_pct);
            if ($urandom_range(99) < chg_pct) randomize_inputs();
        end
    endtask

    // Expects pix_en held high since the reset release just performed.
    task automatic measure_frame(input string tag);
        int cnt, dur;
        bit seen;
        cnt  = 0;
        seen = 0;
        for (int i = 0; i < 3 * FRAME_CLKS && !seen; i++) begin
            @(posedge clock);
            cnt++;
            @(negedge clock);
            if (screenEnd_pulse) seen = 1;
        end
        checkOutput({tag, "_latency"}, seen ? cnt : -1, H_TOTAL * V_ACTIVE + 1);
        dur = 1;
        for (int i = 0; i < FRAME_CLKS; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (!screenEnd) break;
            dur++;
        end
        checkOutput({tag, "_blank_len"}, dur, (V_TOTAL - V_ACTIVE) * H_TOTAL);
    endtask

    initial begin : stimulus
        reset   = 1'b1;
        pix_en  = 1'b0;
        ball_x  = '0;
        ball_y  = '0;
        p1_yRef = '0;
        p2_yRef = '0;
        winner  = '0;
        repeat (3) @(posedge clock);
        #1;
        reset   = 1'b0;
        pix_en  = 1'b1;
        ball_x  = 10'(H_ACTIVE - BALL_W);
        ball_y  = 9'(V_ACTIVE - BALL_H);
        p1_yRef = 9'd2;
        p2_yRef = 9'(V_ACTIVE - 1);
        winner  = 3'd0;
        measure_frame("first_pulse");

        // Frame showing the corner ball; live inputs move underneath it.
        @(posedge clock);
        #1;
        ball_x = 10'd5;
        ball_y = 9'd3;
        winner = 3'd2;
        applyStimulus(FRAME_CLKS, 100, 0);
        applyStimulus(FRAME_CLKS, 100, 0);

        @(posedge clock);
        #1;
        winner = 3'd0;
        applyStimulus(3 * FRAME_CLKS, 70, 4);
        applyStimulus(H_TOTAL * 17 + 13, 100, 4);

        @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset  = 1'b0;
        pix_en = 1'b1;
        measure_frame("reset_pulse");

        applyStimulus(2 * FRAME_CLKS, 100, 3);
        applyStimulus(FRAME_CLKS, 40, 10);
        @(negedge clock);
        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
